conv5x5_filter: RTL

Pixel-rate 5x5 convolution stage that consumes the five vertically aligned line taps and the delayed status word from the line-delay BRAM stage and produces one filtered 8-bit pixel per clock. It builds the horizontal 5x5 window with shift registers, multiplies by a runtime-writable signed coefficient set, sums, scales, clamps and re-aligns the status bits. It sits between the line-delay buffer and the HDMI output encoder.

---
 rtl/conv5x5_filter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/conv5x5_filter.sv
// -----------------------------------------------------------------------------
// conv5x5_filter
//
// Pixel-rate 5x5 convolution stage. Takes five vertically aligned line taps
// from the line-delay buffer plus the status word aligned with the center
// row, builds a 5x5 window with per-row shift registers, multiplies it by a
// runtime-writable signed coefficient set, sums, scales, clamps, and emits one
// unsigned 8-bit pixel per clock together with the re-aligned status word.
//
// Flow control: none. There is no valid/ready pair. Every clock carries one
// pixel, the pipeline never stalls, and DE (stat bit 0) is the only
// qualifier. Output pixels are forced to 0 whenever the delayed DE is 0.
//
// Parameters
//   STAT_W  status word width (bit 0 = DE, upper bits = HS/VS, passed as-is)
//   SHIFT   arithmetic right shift applied to the total (0..6)
//
// Ports
//   clk        pixel clock
//   rst        synchronous active-high reset
//   pa..pe     vertical taps, unsigned; pa = top row 0, pe = bottom row 4
//   stat_i     status aligned with pc (center row)
//   coef_we    coefficient write strobe
//   coef_addr  coefficient index k = 5*row + col (col 0 = oldest); 25..31 ignored
//   coef_din   signed 8-bit coefficient
//   dout       filtered pixel, 7 clocks after the center sample
//   stat_o     stat_i delayed by 7 clocks
//
// Pipeline (edges after input cycle t):
//   t+1 column 4, t+3 center column, t+4 products, t+5 row sums,
//   t+6 total, t+7 clamped dout / stat_o.
// -----------------------------------------------------------------------------
module conv5x5_filter #(
  parameter int STAT_W = 3,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        pa,
  input  logic [7:0]        pb,
  input  logic [7:0]        pc,
  input  logic [7:0]        pd,
  input  logic [7:0]        pe,
  input  logic [STAT_W-1:0] stat_i,
  input  logic              coef_we,
  input  logic [4:0]        coef_addr,
  input  logic [7:0]        coef_din,
  output logic [7:0]        dout,
  output logic [STAT_W-1:0] stat_o
);

  localparam int NTAP = 25;
  // Identity coefficient: a single center tap of 1.0 in the SHIFT fixed point.
  localparam logic [7:0] COEF_ONE = 8'(1 << SHIFT);
  localparam int CENTER = 12;
  // Status is delayed by 6 in this pipe; stat_o adds the 7th stage so that
  // the DE gating dout sees the same delay as the data reaching dout.
  localparam int STAT_DEPTH = 6;

  // ---------------------------------------------------------------------------
  // Tap gathering
  // ---------------------------------------------------------------------------
  logic [7:0] taps [5];

  always_comb begin
    taps[0] = pa;
    taps[1] = pb;
    taps[2] = pc;
    taps[3] = pd;
    taps[4] = pe;
  end

  // ---------------------------------------------------------------------------
  // Window: win[r][4] is the newest sample, win[r][0] the oldest.
  // ---------------------------------------------------------------------------
  logic [7:0] win [5][5];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 5; r++) begin
        for (int j = 0; j < 5; j++) begin
          win[r][j] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < 5; r++) begin
        for (int j = 0; j < 4; j++) begin
          win[r][j] <= win[r][j+1];
        end
        win[r][4] <= taps[r];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Coefficient bank. A write lands at the clock edge and is seen by the
  // product stage on the following edge; the window keeps shifting meanwhile.
  // ---------------------------------------------------------------------------
  logic signed [7:0] coef [NTAP];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAP; k++) begin
        coef[k] <= (k == CENTER) ? COEF_ONE : 8'sd0;
      end
    end else begin
      for (int k = 0; k < NTAP; k++) begin
        if (coef_we && (coef_addr == 5'(k))) begin
          coef[k] <= coef_din;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Products: pixel zero-extended to 9-bit signed times 8-bit signed.
  // ---------------------------------------------------------------------------
  logic signed [16:0] prod_c [5][5];
  logic signed [16:0] prod   [5][5];

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 5; j++) begin
        prod_c[r][j] = $signed({1'b0, win[r][j]}) * coef[5*r + j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 5; r++) begin
        for (int j = 0; j < 5; j++) begin
          prod[r][j] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < 5; r++) begin
        for (int j = 0; j < 5; j++) begin
          prod[r][j] <= prod_c[r][j];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Row sums and total. Widths cover the worst case 25*255*128 < 2^21,
  // so no saturation is needed before the scale stage.
  // ---------------------------------------------------------------------------
  logic signed [19:0] row_sum_c [5];
  logic signed [19:0] row_sum   [5];
  logic signed [21:0] total_c;
  logic signed [21:0] total;

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      row_sum_c[r] = '0;
      for (int j = 0; j < 5; j++) begin
        row_sum_c[r] = row_sum_c[r] + 20'(prod[r][j]);
      end
    end
  end

  always_comb begin
    total_c = '0;
    for (int r = 0; r < 5; r++) begin
      total_c = total_c + 22'(row_sum[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 5; r++) begin
        row_sum[r] <= '0;
      end
      total <= '0;
    end else begin
      for (int r = 0; r < 5; r++) begin
        row_sum[r] <= row_sum_c[r];
      end
      total <= total_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Scale and clamp to the unsigned 8-bit range.
  // ---------------------------------------------------------------------------
  logic signed [21:0] scaled;
  logic [7:0]         clamped;

  always_comb begin
    scaled = total >>> SHIFT;
    if (scaled < 0) begin
      clamped = 8'd0;
    end else if (scaled > 22'sd255) begin
      clamped = 8'd255;
    end else begin
      clamped = scaled[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Status pipe and output register. stat_pipe[STAT_DEPTH-1] is the status
  // matching the total; its DE bit blanks the pixel being registered.
  // ---------------------------------------------------------------------------
  logic [STAT_W-1:0] stat_pipe [STAT_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAT_DEPTH; i++) begin
        stat_pipe[i] <= '0;
      end
      stat_o <= '0;
      dout   <= '0;
    end else begin
      stat_pipe[0] <= stat_i;
      for (int i = 1; i < STAT_DEPTH; i++) begin
        stat_pipe[i] <= stat_pipe[i-1];
      end
      stat_o <= stat_pipe[STAT_DEPTH-1];
      dout   <= stat_pipe[STAT_DEPTH-1][0] ? clamped : 8'd0;
    end
  end

endmodule
